// File: rtl/shift_exec_stage_if.sv
// Issue/writeback bundle for the execute-stage shift unit.
// master = issue + writeback side, slave = the shift stage itself.
interface shift_exec_stage_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic             in_var;
  logic [31:0]      in_a;
  logic [31:0]      in_rs;
  logic [4:0]       in_shamt;
  logic [4:0]       in_dest;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [4:0]       out_dest;
  logic             out_illegal;
  logic [CNT_W-1:0] retired_cnt;

  modport master (
    output in_valid, in_op, in_var, in_a, in_rs, in_shamt, in_dest, out_ready,
    input  in_ready, out_valid, out_result, out_dest, out_illegal, retired_cnt
  );

  modport slave (
    input  in_valid, in_op, in_var, in_a, in_rs, in_shamt, in_dest, out_ready,
    output in_ready, out_valid, out_result, out_dest, out_illegal, retired_cnt
  );
endinterface

// File: rtl/shift_exec_stage.sv
// Two-stage execute shift unit: stage 1 latches the operand and amount,
// the barrel shift sits between stages, stage 2 holds the result for
// writeback under valid/ready with a synchronous flush.
module shift_exec_stage #(
  parameter int CNT_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  shift_exec_stage_if.slave  bus
);
  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  logic             s1_valid;
  logic [31:0]      s1_a;
  logic [4:0]       s1_amt;
  logic [1:0]       s1_op;
  logic [4:0]       s1_dest;

  logic             s2_valid;
  logic [31:0]      s2_result;
  logic [4:0]       s2_dest;
  logic             s2_illegal;
  logic [CNT_W-1:0] cnt;

  logic [4:0]       amt;
  logic [31:0]      sh_res;
  logic             sh_ill;
  logic             adv;
  logic             accept;
  logic             handoff;

  // Only the low five rs bits form a shift amount; the rest is dropped.
  logic unused_rs_hi;
  assign unused_rs_hi = ^bus.in_rs[31:5];

  assign amt     = bus.in_var ? bus.in_rs[4:0] : bus.in_shamt;
  assign adv     = !s2_valid || bus.out_ready;
  assign accept  = bus.in_valid && bus.in_ready;
  assign handoff = s2_valid && bus.out_ready;

  assign bus.in_ready    = !s1_valid || adv;
  assign bus.out_valid   = s2_valid;
  assign bus.out_result  = s2_result;
  assign bus.out_dest    = s2_dest;
  assign bus.out_illegal = s2_illegal;
  assign bus.retired_cnt = cnt;

  // Shift network from stage-1 state; op 11 passes the operand and flags it.
  always_comb begin
    sh_res = s1_a;
    sh_ill = 1'b0;
    case (s1_op)
      OP_SLL:  sh_res = s1_a << s1_amt;
      OP_SRL:  sh_res = s1_a >> s1_amt;
      OP_SRA:  sh_res = $unsigned($signed(s1_a) >>> s1_amt);
      default: sh_ill = 1'b1;
    endcase
  end

  // Stage 1: accept from issue; valid bit dropped by flush.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_amt   <= '0;
      s1_op    <= '0;
      s1_dest  <= '0;
    end else begin
      if (flush)              s1_valid <= 1'b0;
      else if (bus.in_ready)  s1_valid <= bus.in_valid;
      if (accept) begin
        s1_a    <= bus.in_a;
        s1_amt  <= amt;
        s1_op   <= bus.in_op;
        s1_dest <= bus.in_dest;
      end
    end
  end

  // Stage 2: result register, held stable while writeback stalls.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s2_valid   <= 1'b0;
      s2_result  <= '0;
      s2_dest    <= '0;
      s2_illegal <= 1'b0;
    end else begin
      if (flush)     s2_valid <= 1'b0;
      else if (adv)  s2_valid <= s1_valid;
      if (adv && s1_valid) begin
        s2_result  <= sh_res;
        s2_dest    <= s1_dest;
        s2_illegal <= sh_ill;
      end
    end
  end

  // Retired counter: saturating, a handoff on a flush edge still counts.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                      cnt <= '0;
    else if (handoff && cnt != '1)  cnt <= cnt + 1'b1;
  end
endmodule

// File: tb/tb_shift_exec_stage.sv
// Bench for shift_exec_stage: directed vector table, hand sequences for
// backpressure/flush/async reset/saturation, then random traffic vs. a model.
module tb_shift_exec_stage;
  logic clock, reset, flush;

  shift_exec_stage_if #(.CNT_W(16)) bus ();
  shift_exec_stage_if #(.CNT_W(4))  sbus ();

  shift_exec_stage #(.CNT_W(16)) dut  (.clock(clock), .reset(reset), .flush(flush), .bus(bus.slave));
  shift_exec_stage #(.CNT_W(4))  sdut (.clock(clock), .reset(reset), .flush(1'b0),  .bus(sbus.slave));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  op;
    logic        var_sel;
    logic [31:0] a;
    logic [31:0] rs;
    logic [4:0]  shamt;
    logic [4:0]  dest;
    logic [31:0] exp_res;
    logic        exp_ill;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  dest;
    logic        ill;
  } item_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Shift rules as arithmetic: left = multiply by 2^n mod 2^32, logical
  // right = divide, arithmetic right = floor division on a negative value.
  function automatic item_t ref_op(input logic [1:0] op, input logic [31:0] a, input logic [4:0] amt, input logic [4:0] dest);
    item_t r;
    longint unsigned p;
    logic [31:0] na;
    p = 1;
    for (int i = 0; i < int'(amt); i++) p = p * 2;
    r.dest = dest;
    r.ill  = 1'b0;
    case (op)
      2'd0: r.res = 32'((longint'(a) * p) % 64'h1_0000_0000);
      2'd1: r.res = 32'(longint'(a) / p);
      2'd2: begin
        if (a >= 32'h8000_0000) begin
          na = ~a;
          r.res = ~(32'(longint'(na) / p));
        end else r.res = 32'(longint'(a) / p);
      end
      default: begin r.res = a; r.ill = 1'b1; end
    endcase
    return r;
  endfunction

  task automatic drive(input logic [1:0] op, input logic vs, input logic [31:0] a,
                       input logic [31:0] rs, input logic [4:0] sh, input logic [4:0] d);
    bus.in_op = op; bus.in_var = vs; bus.in_a = a; bus.in_rs = rs;
    bus.in_shamt = sh; bus.in_dest = d;
  endtask

  vec_t  vt[$];
  item_t bq[4];
  item_t q[$];
  item_t got, e;
  int    exp_cnt;
  logic [31:0] held;
  logic [31:0] ra, rrs;
  logic [1:0]  rop;
  logic        rvar;
  logic [4:0]  rsh, rd;
  logic        acc, ho;
  logic [15:0] mcnt;

  initial begin
    reset = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    drive(2'd0, 1'b0, '0, '0, '0, '0);
    sbus.in_valid = 1'b0; sbus.out_ready = 1'b0; sbus.in_op = '0; sbus.in_var = 1'b0;
    sbus.in_a = '0; sbus.in_rs = '0; sbus.in_shamt = '0; sbus.in_dest = '0;

    // {op, var, a, rs, shamt, dest, expected result, expected illegal}
    vt.push_back('{2'b10, 1'b0, 32'h8000_0000, 32'h0,         5'd4,  5'd1,  32'hF800_0000, 1'b0});
    vt.push_back('{2'b01, 1'b0, 32'h8000_0000, 32'h0,         5'd4,  5'd2,  32'h0800_0000, 1'b0});
    vt.push_back('{2'b00, 1'b1, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0,  5'd3,  32'h8000_0000, 1'b0});
    vt.push_back('{2'b10, 1'b1, 32'h1234_5678, 32'h0000_0020, 5'd7,  5'd4,  32'h1234_5678, 1'b0});
    vt.push_back('{2'b11, 1'b0, 32'hDEAD_BEEF, 32'h0,         5'd9,  5'd5,  32'hDEAD_BEEF, 1'b1});
    vt.push_back('{2'b01, 1'b1, 32'h0000_0080, 32'hFFFF_FFE3, 5'd0,  5'd6,  32'h0000_0010, 1'b0});
    vt.push_back('{2'b00, 1'b0, 32'hA5A5_A5A5, 32'h0,         5'd0,  5'd7,  32'hA5A5_A5A5, 1'b0});
    vt.push_back('{2'b10, 1'b0, 32'h7FFF_FFFF, 32'h0,         5'd31, 5'd8,  32'h0000_0000, 1'b0});
    vt.push_back('{2'b10, 1'b0, 32'h8765_4321, 32'h0,         5'd31, 5'd9,  32'hFFFF_FFFF, 1'b0});
    vt.push_back('{2'b00, 1'b0, 32'h0000_00FF, 32'h0,         5'd12, 5'd31, 32'h000F_F000, 1'b0});

    // Reset state
    #12;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_result", 64'(bus.out_result), 64'd0);
    chk("rst_retired", 64'(bus.retired_cnt), 64'd0);
    @(negedge clock); reset = 1'b0;
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    tick();

    // Directed vectors, one at a time with writeback always ready
    bus.out_ready = 1'b1;
    foreach (vt[i]) begin
      drive(vt[i].op, vt[i].var_sel, vt[i].a, vt[i].rs, vt[i].shamt, vt[i].dest);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      chk($sformatf("v%0d_lat_valid", i), 64'(bus.out_valid), 64'd0);
      tick();
      chk($sformatf("v%0d_valid", i), 64'(bus.out_valid), 64'd1);
      chk($sformatf("v%0d_result", i), 64'(bus.out_result), 64'(vt[i].exp_res));
      chk($sformatf("v%0d_dest", i), 64'(bus.out_dest), 64'(vt[i].dest));
      chk($sformatf("v%0d_illegal", i), 64'(bus.out_illegal), 64'(vt[i].exp_ill));
      tick();
      chk($sformatf("v%0d_drop", i), 64'(bus.out_valid), 64'd0);
    end
    exp_cnt = vt.size();
    chk("table_retired", 64'(bus.retired_cnt), 64'(exp_cnt));

    // Streaming with backpressure in cycles 3..5
    begin
      int k, j;
      k = 0; j = 0; held = '0;
      for (int b = 0; b < 4; b++)
        bq[b] = ref_op(2'(b % 3), 32'h9000_0001 + 32'(b) * 32'h0101_0101, 5'(b + 1), 5'(10 + b));
      for (int c = 0; c < 20; c++) begin
        bus.out_ready = !(c >= 3 && c <= 5);
        bus.in_valid  = (k < 4);
        if (k < 4) drive(2'(k % 3), 1'b0, 32'h9000_0001 + 32'(k) * 32'h0101_0101, '0, 5'(k + 1), 5'(10 + k));
        @(negedge clock);
        if (c >= 3 && c <= 5) chk($sformatf("bp_in_ready_c%0d", c), 64'(bus.in_ready), 64'd0);
        if (c == 3) held = bus.out_result;
        if (c == 4 || c == 5) begin
          chk($sformatf("bp_hold_valid_c%0d", c), 64'(bus.out_valid), 64'd1);
          chk($sformatf("bp_hold_result_c%0d", c), 64'(bus.out_result), 64'(held));
        end
        if (bus.in_valid && bus.in_ready) k++;
        if (bus.out_valid && bus.out_ready) begin
          if (j < 4) begin
            chk($sformatf("bp_res%0d", j), 64'(bus.out_result), 64'(bq[j].res));
            chk($sformatf("bp_dest%0d", j), 64'(bus.out_dest), 64'(bq[j].dest));
          end
          j++;
        end
        tick();
      end
      bus.in_valid = 1'b0;
      chk("bp_delivered", 64'(j), 64'd4);
      exp_cnt += 4;
      chk("bp_retired", 64'(bus.retired_cnt), 64'(exp_cnt));
    end

    // Flush with both stages full and a same-cycle input
    bus.out_ready = 1'b0;
    drive(2'd0, 1'b0, 32'h1, '0, 5'd1, 5'd1); bus.in_valid = 1'b1; tick();
    drive(2'd1, 1'b0, 32'h2, '0, 5'd1, 5'd2); tick();
    drive(2'd2, 1'b0, 32'h3, '0, 5'd1, 5'd3); flush = 1'b1; tick();
    flush = 1'b0; bus.in_valid = 1'b0;
    chk("fl_valid0", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("fl_empty%0d", c), 64'(bus.out_valid), 64'd0);
    end
    chk("fl_retired", 64'(bus.retired_cnt), 64'(exp_cnt));
    drive(2'd0, 1'b0, 32'h3, '0, 5'd2, 5'd4); bus.in_valid = 1'b1; tick();
    bus.in_valid = 1'b0; tick();
    chk("fl_after_valid", 64'(bus.out_valid), 64'd1);
    chk("fl_after_result", 64'(bus.out_result), 64'd12);
    chk("fl_after_dest", 64'(bus.out_dest), 64'd4);
    tick();
    exp_cnt++;
    chk("fl_after_retired", 64'(bus.retired_cnt), 64'(exp_cnt));

    // Asynchronous reset between edges with a result waiting
    bus.out_ready = 1'b0;
    drive(2'd0, 1'b0, 32'h5, '0, 5'd1, 5'd9); bus.in_valid = 1'b1; tick();
    bus.in_valid = 1'b0; tick();
    chk("ar_pre_valid", 64'(bus.out_valid), 64'd1);
    @(negedge clock); reset = 1'b1; #1;
    chk("ar_valid", 64'(bus.out_valid), 64'd0);
    chk("ar_result", 64'(bus.out_result), 64'd0);
    chk("ar_dest", 64'(bus.out_dest), 64'd0);
    chk("ar_illegal", 64'(bus.out_illegal), 64'd0);
    chk("ar_retired", 64'(bus.retired_cnt), 64'd0);
    @(negedge clock); reset = 1'b0; #1;
    chk("ar_in_ready", 64'(bus.in_ready), 64'd1);
    tick();

    // Saturation on the 4-bit counter instance: 20 handoffs
    sbus.out_ready = 1'b1; sbus.in_valid = 1'b1; sbus.in_op = 2'b11; sbus.in_a = 32'h55;
    for (int c = 0; c < 20; c++) tick();
    sbus.in_valid = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    chk("sat_retired", 64'(sbus.retired_cnt), 64'hF);

    // Random traffic against the queue model
    @(negedge clock); reset = 1'b1; @(negedge clock); reset = 1'b0;
    tick();
    q.delete();
    mcnt = '0;
    for (int c = 0; c < 330; c++) begin
      rop = 2'($urandom_range(0, 3)); rvar = 1'($urandom_range(0, 1));
      ra = $urandom; rrs = $urandom; rsh = 5'($urandom_range(0, 31)); rd = 5'($urandom_range(0, 31));
      drive(rop, rvar, ra, rrs, rsh, rd);
      bus.in_valid  = (c < 300) && ($urandom_range(0, 3) != 0);
      bus.out_ready = (c >= 300) || ($urandom_range(0, 2) != 0);
      flush         = (c < 300) && ($urandom_range(0, 24) == 0);
      @(negedge clock);
      acc = bus.in_valid && bus.in_ready;
      ho  = bus.out_valid && bus.out_ready;
      if (bus.out_valid && q.size() == 0) chk("rnd_spurious_valid", 64'(bus.out_valid), 64'd0);
      if (ho) begin
        if (q.size() == 0) chk("rnd_handoff_empty", 64'd1, 64'd0);
        else begin
          e = q.pop_front();
          got.res = bus.out_result; got.dest = bus.out_dest; got.ill = bus.out_illegal;
          chk("rnd_item", {got.res, 26'd0, got.dest, got.ill}, {e.res, 26'd0, e.dest, e.ill});
        end
        if (mcnt != 16'hFFFF) mcnt++;
      end
      if (flush) q.delete();
      else if (acc) q.push_back(ref_op(rop, ra, rvar ? rrs[4:0] : rsh, rd));
      tick();
      chk("rnd_retired", 64'(bus.retired_cnt), 64'(mcnt));
    end
    flush = 1'b0;
    chk("rnd_drained", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
